// File: rtl/game_referee.sv
// game_referee: match controller that sequences main_counter through
// load/run/end, scores rising edges of its winner/loser flags and declares
// game over when either score reaches WIN_LIMIT.
module game_referee #(
    parameter int unsigned WIN_LIMIT = 15,
    parameter int unsigned SCORE_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode_sel,
    input  logic [3:0]         seed,
    input  logic               winner,
    input  logic               loser,
    output logic               init,
    output logic [3:0]         initial_val,
    output logic [1:0]         control,
    output logic [SCORE_W-1:0] win_count,
    output logic [SCORE_W-1:0] lose_count,
    output logic [1:0]         who,
    output logic               gameover,
    output logic               busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StOver = 2'd3;

    localparam logic [SCORE_W-1:0] Limit = SCORE_W'(WIN_LIMIT);

    logic [1:0]         state_q, state_d;
    logic               init_q, init_d;
    logic [3:0]         initial_val_q, initial_val_d;
    logic [1:0]         control_q, control_d;
    logic [SCORE_W-1:0] win_count_q, win_count_d;
    logic [SCORE_W-1:0] lose_count_q, lose_count_d;
    logic [1:0]         who_q, who_d;
    logic               gameover_q, gameover_d;
    logic               busy_q, busy_d;
    logic               winner_q, loser_q;

    logic               win_rise, lose_rise;
    logic               win_hit, lose_hit;

    // Rising-edge events on the counter flags
    always_comb begin
        win_rise  = winner & ~winner_q;
        lose_rise = loser & ~loser_q;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        init_d        = 1'b0;
        initial_val_d = initial_val_q;
        control_d     = control_q;
        win_count_d   = win_count_q;
        lose_count_d  = lose_count_q;
        who_d         = who_q;
        gameover_d    = gameover_q;
        busy_d        = busy_q;
        win_hit       = 1'b0;
        lose_hit      = 1'b0;

        case (state_q)
            StIdle, StOver: begin
                // Results stay frozen until LOAD clears them
                if (start) begin
                    control_d     = mode_sel;
                    initial_val_d = seed;
                    init_d        = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = StLoad;
                end
            end
            StLoad: begin
                win_count_d  = '0;
                lose_count_d = '0;
                who_d        = 2'b00;
                gameover_d   = 1'b0;
                state_d      = StRun;
            end
            StRun: begin
                win_count_d  = win_count_q + SCORE_W'(win_rise);
                lose_count_d = lose_count_q + SCORE_W'(lose_rise);
                win_hit      = (win_count_d == Limit);
                lose_hit     = (lose_count_d == Limit);
                if (win_hit || lose_hit) begin
                    who_d      = {lose_hit, win_hit};
                    gameover_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = StOver;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any game in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            init_q        <= 1'b0;
            initial_val_q <= 4'd0;
            control_q     <= 2'd0;
            win_count_q   <= '0;
            lose_count_q  <= '0;
            who_q         <= 2'b00;
            gameover_q    <= 1'b0;
            busy_q        <= 1'b0;
            winner_q      <= 1'b0;
            loser_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_q        <= init_d;
            initial_val_q <= initial_val_d;
            control_q     <= control_d;
            win_count_q   <= win_count_d;
            lose_count_q  <= lose_count_d;
            who_q         <= who_d;
            gameover_q    <= gameover_d;
            busy_q        <= busy_d;
            winner_q      <= winner;
            loser_q       <= loser;
        end
    end

    // Drive ports straight from registers
    always_comb begin
        init        = init_q;
        initial_val = initial_val_q;
        control     = control_q;
        win_count   = win_count_q;
        lose_count  = lose_count_q;
        who         = who_q;
        gameover    = gameover_q;
        busy        = busy_q;
    end

endmodule

// File: tb/tb_game_referee.sv
// tb_game_referee: directed scenarios plus randomized traffic, every cycle
// compared against a cycle-level game model kept in plain integers.
module tb_game_referee;

    localparam int WL = 3;
    localparam int SW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode_sel;
    logic [3:0]    seed;
    logic          winner;
    logic          loser;
    logic          init;
    logic [3:0]    initial_val;
    logic [1:0]    control;
    logic [SW-1:0] win_count;
    logic [SW-1:0] lose_count;
    logic [1:0]    who;
    logic          gameover;
    logic          busy;

    game_referee #(
        .WIN_LIMIT(WL),
        .SCORE_W  (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode_sel   (mode_sel),
        .seed       (seed),
        .winner     (winner),
        .loser      (loser),
        .init       (init),
        .initial_val(initial_val),
        .control    (control),
        .win_count  (win_count),
        .lose_count (lose_count),
        .who        (who),
        .gameover   (gameover),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 loading, 2 playing, 3 finished
    int m_phase, m_init, m_ival, m_ctrl, m_win, m_lose, m_who, m_go, m_busy;
    int m_wprev, m_lprev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_init = 0; m_ival = 0; m_ctrl = 0;
        m_win = 0; m_lose = 0; m_who = 0; m_go = 0; m_busy = 0;
        m_wprev = 0; m_lprev = 0;
    endtask

    // One rising clock edge of the game rules, using the inputs present now
    task automatic model_edge();
        int wr, lr;
        wr = (winner && m_wprev == 0) ? 1 : 0;
        lr = (loser && m_lprev == 0) ? 1 : 0;
        m_init = 0;
        if (m_phase == 0 || m_phase == 3) begin
            if (start) begin
                m_ctrl = int'(mode_sel); m_ival = int'(seed);
                m_init = 1; m_busy = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_win = 0; m_lose = 0; m_who = 0; m_go = 0; m_phase = 2;
        end else begin
            m_win += wr;
            m_lose += lr;
            if (m_win == WL || m_lose == WL) begin
                m_who = (m_win == WL ? 1 : 0) + (m_lose == WL ? 2 : 0);
                m_go = 1; m_busy = 0; m_phase = 3;
            end
        end
        m_wprev = winner ? 1 : 0;
        m_lprev = loser ? 1 : 0;
    endtask

    task automatic check_all();
        check("init", 32'(init), 32'(m_init));
        check("initial_val", 32'(initial_val), 32'(m_ival));
        check("control", 32'(control), 32'(m_ctrl));
        check("win_count", 32'(win_count), 32'(m_win));
        check("lose_count", 32'(lose_count), 32'(m_lose));
        check("who", 32'(who), 32'(m_who));
        check("gameover", 32'(gameover), 32'(m_go));
        check("busy", 32'(busy), 32'(m_busy));
    endtask

    // Advance one cycle, update model on the edge, compare 1ns later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic s, input logic [1:0] m, input logic [3:0] sd,
                         input logic w, input logic l);
        start = s; mode_sel = m; seed = sd; winner = w; loser = l;
    endtask

    // Asynchronous reset pulse entirely between clock edges
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_busy_now", 32'(busy), 32'd0);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_w(input logic l);
        drive(1'b0, 2'd0, 4'd0, 1'b1, l); step();
        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0); step();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
        model_reset();
        #3;
        check_all();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("idle_init", 32'(init), 32'd0);

        // Game start; loser already high before RUN must not count
        drive(1'b1, 2'd2, 4'd5, 1'b0, 1'b1); step();
        check("start_init", 32'(init), 32'd1);
        check("start_ival", 32'(initial_val), 32'd5);
        check("start_ctrl", 32'(control), 32'd2);
        check("start_busy", 32'(busy), 32'd1);
        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b1); step();
        check("load_init_low", 32'(init), 32'd0);

        // Winner held 4 cycles, low, 1-cycle pulse
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 4'd0, 1'b1, 1'b1); step();
        end
        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b1); step();
        drive(1'b0, 2'd0, 4'd0, 1'b1, 1'b1); step();
        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b1); step();
        check("edge_win2", 32'(win_count), 32'd2);
        check("edge_lose0", 32'(lose_count), 32'd0);

        // Third winner event ends the game
        drive(1'b0, 2'd0, 4'd0, 1'b1, 1'b0); step();
        check("limit_go", 32'(gameover), 32'd1);
        check("limit_who", 32'(who), 32'd1);
        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0); step();
        pulse_w(1'b0);
        pulse_w(1'b0);
        check("frozen_win3", 32'(win_count), 32'd3);

        // Restart from OVER with seed 9
        drive(1'b1, 2'd1, 4'd9, 1'b0, 1'b0); step();
        check("restart_init", 32'(init), 32'd1);
        check("restart_ival", 32'(initial_val), 32'd9);
        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0); step();
        check("restart_clear", 32'(win_count), 32'd0);
        check("restart_go0", 32'(gameover), 32'd0);

        // Tie: simultaneous winner and loser events three times
        for (int i = 0; i < 3; i++) pulse_w(1'b1);
        check("tie_who", 32'(who), 32'd3);

        // Reset in the middle of a run with win_count at 2
        drive(1'b1, 2'd3, 4'd7, 1'b0, 1'b0); step();
        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0); step();
        pulse_w(1'b0);
        pulse_w(1'b0);
        check("pre_rst_win2", 32'(win_count), 32'd2);
        mid_reset();
        check("post_rst_win0", 32'(win_count), 32'd0);
        drive(1'b1, 2'd1, 4'd3, 1'b0, 1'b0); step();
        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0); step();
        for (int i = 0; i < 3; i++) pulse_w(1'b0);
        check("after_rst_go", 32'(gameover), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 7) == 0), 2'($urandom), 4'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            step();
            if ($urandom_range(0, 199) == 0) mid_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
